snake_step_ctrl: RTL and testbench

Per-player snake head motion controller sitting directly downstream of the PS/2 key decoder in the snake game top level. It converts level-style arrow/WASD key flags into a committed heading, advances the head one cell per game tick with screen wrap-around on the 160x120 grid, and offers each new head coordinate to the drawing/collision stage through a valid/ready handshake. The top level instantiates it once for player 1 (arrow keys) and once for player 2 (WASD).

---
 rtl/snake_pkg.sv | 22 ++
 rtl/snake_tick_gen.sv | 32 +++
 rtl/snake_step_ctrl.sv | 154 +++++++++++++++
 tb/tb_snake_step_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake head motion controller.
// Holds the heading encoding, the default grid size and the controller
// state enum so the top level, sub-module and bench agree on them.
package snake_pkg;

  // Heading encoding; bit 1 selects the axis (0 vertical, 1 horizontal),
  // so two headings are opposite when bit 1 matches and the values differ.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int H_RES_DEF = 160;
  localparam int V_RES_DEF = 120;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

endpackage

// File: rtl/snake_tick_gen.sv
// Game tick generator: free-running modulo-STEP_CYCLES counter.
// Latency: o_tick is high for the one cycle in which the counter holds STEP_CYCLES-1.
// Backpressure: none; i_clear holds the count at 0 and masks the tick.
// Ports: CLOCK_50/reset (sync, active-high), i_clear, o_tick.
module snake_tick_gen #(
  parameter int STEP_CYCLES = 5_000_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = $clog2(STEP_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(STEP_CYCLES - 1));
  assign o_tick = w_last && !i_clear;

  always_ff @(posedge CLOCK_50) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snake_step_ctrl.sv
// Snake head motion controller: key flags -> committed heading, one cell per tick with wrap.
// Latency: first step_valid STEP_CYCLES edges after game_en is sampled; outputs registered.
// Backpressure: step held until step_ready; ticks arriving while held are dropped and flag overrun.
// Ports: CLOCK_50, reset (sync, active-high), game_en, key_up/down/left/right, step_ready in;
//        step_valid, head_x[7:0], head_y[6:0], dir[1:0], overrun (sticky) out.
module snake_step_ctrl
  import snake_pkg::*;
#(
  parameter int         STEP_CYCLES = 5_000_000,
  parameter int         H_RES       = H_RES_DEF,
  parameter int         V_RES       = V_RES_DEF,
  parameter int         START_X     = 80,
  parameter int         START_Y     = 60,
  parameter logic [1:0] START_DIR   = DIR_RIGHT
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       game_en,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       step_ready,
  output logic       step_valid,
  output logic [7:0] head_x,
  output logic [6:0] head_y,
  output logic [1:0] dir,
  output logic       overrun
);

  state_t     r_state;
  logic [7:0] r_head_x;
  logic [6:0] r_head_y;
  logic [1:0] r_dir;
  logic [1:0] r_pend_dir;
  logic       r_step_valid;
  logic       r_overrun;

  state_t     w_state_nxt;
  logic [7:0] w_x_nxt, w_mv_x;
  logic [6:0] w_y_nxt, w_mv_y;
  logic [1:0] w_dir_nxt, w_pend_nxt, w_pend_upd, w_req;
  logic       w_vld_nxt, w_ovr_nxt, w_move, w_tick, w_tick_clr, w_key_any;

  // Counter sits at 0 while idle and is cleared on the edge that enters idle.
  assign w_tick_clr = (r_state == ST_IDLE) || !game_en;

  snake_tick_gen #(.STEP_CYCLES(STEP_CYCLES)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .i_clear  (w_tick_clr),
    .o_tick   (w_tick)
  );

  // Key priority up > down > left > right. Reversal is judged against the
  // committed heading so two presses within one tick cannot turn 180 degrees.
  always_comb begin
    w_key_any = key_up || key_down || key_left || key_right;
    w_req     = DIR_RIGHT;
    if (key_up)        w_req = DIR_UP;
    else if (key_down) w_req = DIR_DOWN;
    else if (key_left) w_req = DIR_LEFT;
    w_pend_upd = r_pend_dir;
    if (w_key_any && !((r_dir[1] == w_req[1]) && (r_dir != w_req))) begin
      w_pend_upd = w_req;
    end
  end

  // Next head cell along the pending heading; bound checked before the
  // add/subtract so the result is always inside the grid.
  always_comb begin
    w_mv_x = r_head_x;
    w_mv_y = r_head_y;
    case (r_pend_dir)
      DIR_UP:    w_mv_y = (r_head_y == 7'd0) ? 7'(V_RES - 1) : r_head_y - 7'd1;
      DIR_DOWN:  w_mv_y = (r_head_y == 7'(V_RES - 1)) ? 7'd0 : r_head_y + 7'd1;
      DIR_LEFT:  w_mv_x = (r_head_x == 8'd0) ? 8'(H_RES - 1) : r_head_x - 8'd1;
      DIR_RIGHT: w_mv_x = (r_head_x == 8'(H_RES - 1)) ? 8'd0 : r_head_x + 8'd1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_head_x;
    w_y_nxt     = r_head_y;
    w_dir_nxt   = r_dir;
    w_pend_nxt  = r_pend_dir;
    w_vld_nxt   = r_step_valid;
    w_ovr_nxt   = r_overrun;
    w_move      = 1'b0;
    if (!game_en) begin
      w_state_nxt = ST_IDLE;
      w_x_nxt     = 8'(START_X);
      w_y_nxt     = 7'(START_Y);
      w_dir_nxt   = START_DIR;
      w_pend_nxt  = START_DIR;
      w_vld_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_RUN;
        ST_RUN: begin
          w_pend_nxt = w_pend_upd;
          w_move     = w_tick;
        end
        ST_PEND: begin
          w_pend_nxt = w_pend_upd;
          if (step_ready) begin
            // Handshake completing on a tick edge frees the slot for that tick.
            w_vld_nxt   = 1'b0;
            w_state_nxt = ST_RUN;
            w_move      = w_tick;
          end else if (w_tick) begin
            w_ovr_nxt = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
      if (w_move) begin
        w_dir_nxt   = r_pend_dir;
        w_x_nxt     = w_mv_x;
        w_y_nxt     = w_mv_y;
        w_vld_nxt   = 1'b1;
        w_state_nxt = ST_PEND;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_head_x     <= 8'(START_X);
      r_head_y     <= 7'(START_Y);
      r_dir        <= START_DIR;
      r_pend_dir   <= START_DIR;
      r_step_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_head_x     <= w_x_nxt;
      r_head_y     <= w_y_nxt;
      r_dir        <= w_dir_nxt;
      r_pend_dir   <= w_pend_nxt;
      r_step_valid <= w_vld_nxt;
      r_overrun    <= w_ovr_nxt;
    end
  end

  assign step_valid = r_step_valid;
  assign head_x     = r_head_x;
  assign head_y     = r_head_y;
  assign dir        = r_dir;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_snake_step_ctrl.sv
module tb_snake_step_ctrl;

  localparam int STEP = 4;
  localparam int H    = 160;
  localparam int V    = 120;
  localparam int NV   = 24;

  logic       CLOCK_50 = 1'b0;
  logic       reset, game_en, key_up, key_down, key_left, key_right, step_ready;
  logic       step_valid, overrun;
  logic [7:0] head_x;
  logic [6:0] head_y;
  logic [1:0] dir;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  snake_step_ctrl #(.STEP_CYCLES(STEP)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .game_en    (game_en),
    .key_up     (key_up),
    .key_down   (key_down),
    .key_left   (key_left),
    .key_right  (key_right),
    .step_ready (step_ready),
    .step_valid (step_valid),
    .head_x     (head_x),
    .head_y     (head_y),
    .dir        (dir),
    .overrun    (overrun)
  );

  // Behavioural reference: "active" = game enabled for at least one edge,
  // "busy" = a step is on offer. Wrap via modular arithmetic.
  bit m_act, m_vld, m_ovr;
  int m_cnt, m_x, m_y, m_dir, m_pend;

  task automatic model_start();
    m_act = 0; m_vld = 0; m_cnt = 0;
    m_x = 80; m_y = 60; m_dir = 3; m_pend = 3;
  endtask

  task automatic model_step();
    int  req, nxt_pend;
    bit  tick;
    if (reset) begin
      model_start();
      m_ovr = 0;
    end else if (!game_en) begin
      model_start();
    end else if (!m_act) begin
      m_act = 1;
      m_cnt = 0;
    end else begin
      tick  = (m_cnt == STEP - 1);
      m_cnt = (m_cnt + 1) % STEP;
      req   = key_up ? 0 : key_down ? 1 : key_left ? 2 : key_right ? 3 : -1;
      nxt_pend = m_pend;
      if (req >= 0 && req != (m_dir ^ 1)) nxt_pend = req;
      if (m_vld && step_ready) m_vld = 0;
      if (tick) begin
        if (m_vld) m_ovr = 1;
        else begin
          m_dir = m_pend;
          case (m_dir)
            0: m_y = (m_y + V - 1) % V;
            1: m_y = (m_y + 1) % V;
            2: m_x = (m_x + H - 1) % H;
            default: m_x = (m_x + 1) % H;
          endcase
          m_vld = 1;
        end
      end
      m_pend = nxt_pend;
    end
  endtask

  task automatic check_out(string name, logic e_vld, int e_x, int e_y, int e_dir, logic e_ovr);
    vectors++;
    if (step_valid !== e_vld || int'(head_x) != e_x || int'(head_y) != e_y ||
        int'(dir) != e_dir || overrun !== e_ovr) begin
      miscompares++;
      $display("FAIL %s: got vld=%0b x=%0d y=%0d dir=%0d ovr=%0b, want vld=%0b x=%0d y=%0d dir=%0d ovr=%0b",
               name, step_valid, head_x, head_y, dir, overrun, e_vld, e_x, e_y, e_dir, e_ovr);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLOCK_50);
    #1;
    check_out("model", m_vld, m_x, m_y, m_dir, m_ovr);
  endtask

  task automatic set_keys(logic [3:0] k);
    {key_up, key_down, key_left, key_right} = k;
  endtask

  task automatic wait_step(string name);
    bit got = 0;
    for (int k = 0; k < 12 && !got; k++) begin
      cycle();
      if (step_valid === 1'b1) got = 1;
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: step_valid never rose within 12 cycles", name);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] keys;   // {up, down, left, right}
    logic       rdy;
    int         ncyc;
    logic       e_vld;
    int         e_x;
    int         e_y;
    int         e_dir;
    logic       e_ovr;
  } vec_t;

  vec_t tbl [NV];

  initial begin
    // rst en keys rdy ncyc | vld x y dir ovr
    tbl[0]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 1,  1'b0, 80, 60, 3, 1'b0}; // reset state
    tbl[1]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 1,  1'b0, 80, 60, 3, 1'b0}; // game_en sampled
    tbl[2]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 3,  1'b0, 80, 60, 3, 1'b0}; // not yet
    tbl[3]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 1,  1'b1, 81, 60, 3, 1'b0}; // first step
    tbl[4]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 1,  1'b0, 81, 60, 3, 1'b0}; // handshake
    tbl[5]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 3,  1'b1, 82, 60, 3, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 4,  1'b1, 83, 60, 3, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 4'b0010, 1'b1, 1,  1'b0, 83, 60, 3, 1'b0}; // left pulse
    tbl[8]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 3,  1'b1, 84, 60, 3, 1'b0}; // reversal ignored
    tbl[9]  = '{1'b0, 1'b1, 4'b1001, 1'b1, 1,  1'b0, 84, 60, 3, 1'b0}; // up+right
    tbl[10] = '{1'b0, 1'b1, 4'b0000, 1'b1, 3,  1'b1, 84, 59, 0, 1'b0}; // up wins
    tbl[11] = '{1'b0, 1'b1, 4'b0001, 1'b1, 1,  1'b0, 84, 59, 0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 4'b0000, 1'b1, 3,  1'b1, 85, 59, 3, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 4'b1000, 1'b1, 1,  1'b0, 85, 59, 3, 1'b0}; // up then
    tbl[14] = '{1'b0, 1'b1, 4'b0010, 1'b1, 3,  1'b1, 85, 58, 0, 1'b0}; // left in same tick
    tbl[15] = '{1'b0, 1'b1, 4'b0010, 1'b1, 4,  1'b1, 84, 58, 2, 1'b0}; // left next tick
    tbl[16] = '{1'b0, 1'b1, 4'b0000, 1'b0, 10, 1'b1, 84, 58, 2, 1'b1}; // stalled -> overrun
    tbl[17] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1,  1'b0, 84, 58, 2, 1'b1}; // transfer
    tbl[18] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1,  1'b1, 83, 58, 2, 1'b1}; // one cell further
    tbl[19] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1,  1'b0, 80, 60, 3, 1'b1}; // game_en drop
    tbl[20] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1,  1'b0, 80, 60, 3, 1'b1};
    tbl[21] = '{1'b0, 1'b1, 4'b0000, 1'b1, 4,  1'b1, 81, 60, 3, 1'b1};
    tbl[22] = '{1'b1, 1'b1, 4'b0000, 1'b1, 1,  1'b0, 80, 60, 3, 1'b0}; // reset mid-step
    tbl[23] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1,  1'b0, 80, 60, 3, 1'b0};

    reset = 1'b1; game_en = 1'b0; step_ready = 1'b1; set_keys(4'b0000);
    model_start();
    m_ovr = 0;

    for (int i = 0; i < NV; i++) begin
      reset      = tbl[i].rst;
      game_en    = tbl[i].en;
      step_ready = tbl[i].rdy;
      set_keys(tbl[i].keys);
      repeat (tbl[i].ncyc) cycle();
      check_out($sformatf("vec%0d", i), tbl[i].e_vld, tbl[i].e_x, tbl[i].e_y,
                tbl[i].e_dir, tbl[i].e_ovr);
    end

    // Right edge wrap: 79 steps reach x=159, the 80th wraps to 0.
    reset = 1'b0; game_en = 1'b1; step_ready = 1'b1; set_keys(4'b0000);
    for (int s = 1; s <= 79; s++) wait_step("wrap_x_walk");
    check_out("x_at_159", 1'b1, 159, 60, 3, 1'b0);
    wait_step("wrap_x_step");
    check_out("x_wrap_to_0", 1'b1, 0, 60, 3, 1'b0);

    // Top edge wrap: 60 steps up reach y=0, the next wraps to 119.
    set_keys(4'b1000);
    for (int s = 1; s <= 60; s++) wait_step("wrap_y_walk");
    check_out("y_at_0", 1'b1, 0, 0, 0, 1'b0);
    wait_step("wrap_y_step");
    check_out("y_wrap_to_119", 1'b1, 0, 119, 0, 1'b0);

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 199) == 0);
      game_en    = ($urandom_range(0, 49) != 0);
      step_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) set_keys(4'($urandom));
      else set_keys(4'b0000);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
